draw_sequencer: RTL and testbench

Pixel-sweep controller that sits directly upstream of the game datapath's ROM and colour path. On a `start` request it walks every pixel of either a full 160x120 screen image or a 40x40 sprite. For each pixel it issues the ROM address, compensates for the ROM read latency, and presents aligned `x`/`y`/`color`/`plot` to the VGA adapter. It reports completion with a one-cycle `done` pulse so the game FSM can sequence title, choose, fight and win screens.

---
 rtl/draw_sequencer.sv | 146 ++++++++++++++
 tb/tb_draw_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// Pixel-sweep controller: walks a full screen or a sprite row-major, issues ROM addresses and
// presents latency-aligned x/y/color/plot to the VGA adapter, then pulses done.
module draw_sequencer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  parameter int ROM_LAT  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        mode,
  input  logic        black,
  input  logic [7:0]  x_origin,
  input  logic [6:0]  y_origin,
  output logic [14:0] rom_addr,
  input  logic [2:0]  rom_color,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  color,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0] state;
  logic       modeQ;
  logic       blackQ;
  logic [7:0] xOrgQ;
  logic [6:0] yOrgQ;
  logic [7:0] col;
  logic [6:0] row;
  logic [1:0] drainCnt;

  logic [ROM_LAT-1:0] pipePlot;
  logic [7:0]         pipeX [ROM_LAT];
  logic [6:0]         pipeY [ROM_LAT];

  logic [7:0] lastCol;
  logic [6:0] lastRow;
  logic [8:0] xSum;
  logic [7:0] ySum;
  logic       clip;
  logic       sweepEnd;

  assign lastCol  = modeQ ? 8'(SPRITE_W - 1) : 8'(SCREEN_W - 1);
  assign lastRow  = modeQ ? 7'(SPRITE_H - 1) : 7'(SCREEN_H - 1);
  // Widened sums keep off-screen sprite pixels detectable instead of wrapping.
  assign xSum     = modeQ ? ({1'b0, xOrgQ} + {1'b0, col}) : {1'b0, col};
  assign ySum     = modeQ ? ({1'b0, yOrgQ} + {1'b0, row}) : {1'b0, row};
  assign clip     = (xSum >= 9'(SCREEN_W)) || (ySum >= 8'(SCREEN_H));
  assign sweepEnd = (col == lastCol) && (row == lastRow);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= StIdle;
      modeQ    <= 1'b0;
      blackQ   <= 1'b0;
      xOrgQ    <= 8'd0;
      yOrgQ    <= 7'd0;
      col      <= 8'd0;
      row      <= 7'd0;
      rom_addr <= 15'd0;
      drainCnt <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            state    <= StSweep;
            busy     <= 1'b1;
            modeQ    <= mode;
            blackQ   <= black;
            xOrgQ    <= x_origin;
            yOrgQ    <= y_origin;
            col      <= 8'd0;
            row      <= 7'd0;
            rom_addr <= 15'd0;
          end
        end
        StSweep: begin
          if (sweepEnd) begin
            state    <= StDrain;
            drainCnt <= 2'd0;
          end else begin
            rom_addr <= rom_addr + 15'd1;
            if (col == lastCol) begin
              col <= 8'd0;
              row <= row + 7'd1;
            end else begin
              col <= col + 8'd1;
            end
          end
        end
        StDrain: begin
          if (drainCnt == 2'(ROM_LAT - 1)) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drainCnt <= drainCnt + 2'd1;
          end
        end
        StDone: begin
          state <= StIdle;
          done  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Coordinate/visibility pipeline matches the ROM read latency slot for slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipePlot <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        pipeX[i] <= 8'd0;
        pipeY[i] <= 7'd0;
      end
    end else begin
      pipePlot[0] <= (state == StSweep) && !clip;
      pipeX[0]    <= xSum[7:0];
      pipeY[0]    <= ySum[6:0];
      for (int i = 1; i < ROM_LAT; i++) begin
        pipePlot[i] <= pipePlot[i-1];
        pipeX[i]    <= pipeX[i-1];
        pipeY[i]    <= pipeY[i-1];
      end
    end
  end

  assign plot  = pipePlot[ROM_LAT-1];
  assign x     = pipeX[ROM_LAT-1];
  assign y     = pipeY[ROM_LAT-1];
  // ROM data is already registered and lands in the same cycle as its pipeline slot.
  assign color = (plot && !blackQ) ? rom_color : 3'b000;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: ROM_LAT=1 and ROM_LAT=2 instances share stimulus and are checked
// every cycle against a cycle-indexed arithmetic model of the draw.
module tb_draw_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       black = 1'b0;
  logic [7:0] xo = 8'd0;
  logic [6:0] yo = 7'd0;

  logic [14:0] a1, a2;
  logic [2:0]  q1, q2, q2a;
  logic [7:0]  x1, x2;
  logic [6:0]  y1, y2;
  logic [2:0]  c1, c2;
  logic        p1, p2, b1, b2, d1, d2;

  draw_sequencer #(.ROM_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .black(black),
    .x_origin(xo), .y_origin(yo), .rom_addr(a1), .rom_color(q1),
    .x(x1), .y(y1), .color(c1), .plot(p1), .busy(b1), .done(d1)
  );

  draw_sequencer #(.ROM_LAT(2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .black(black),
    .x_origin(xo), .y_origin(yo), .rom_addr(a2), .rom_color(q2),
    .x(x2), .y(y2), .color(c2), .plot(p2), .busy(b2), .done(d2)
  );

  // ROM models return addr[2:0] after 1 or 2 cycles.
  always @(posedge clk) q1 <= a1[2:0];
  always @(posedge clk) begin
    q2a <= a2[2:0];
    q2  <= q2a;
  end

  logic [14:0] oAddr [2];
  logic [7:0]  oX [2];
  logic [6:0]  oY [2];
  logic [2:0]  oColor [2];
  logic        oPlot [2];
  logic        oBusy [2];
  logic        oDone [2];
  assign oAddr[0] = a1;   assign oAddr[1] = a2;
  assign oX[0] = x1;      assign oX[1] = x2;
  assign oY[0] = y1;      assign oY[1] = y2;
  assign oColor[0] = c1;  assign oColor[1] = c2;
  assign oPlot[0] = p1;   assign oPlot[1] = p2;
  assign oBusy[0] = b1;   assign oBusy[1] = b2;
  assign oDone[0] = d1;   assign oDone[1] = d2;

  int checks = 0;
  int errors = 0;

  // Expectations supplied by the stimulus for the next draw.
  int tExp = 0;
  int tDone1 = 0;
  int tDone2 = 0;

  // Reference model: per instance, idle flag and cycle index since start was sampled.
  bit mIdle [2] = '{1'b1, 1'b1};
  bit mRst [2] = '{1'b1, 1'b1};
  int mCyc [2];
  bit mMode [2];
  bit mBlack [2];
  int mOx [2];
  int mOy [2];
  int mExp [2];
  int mDone [2];
  int plotCnt [2];

  function automatic int lastCyc(bit m, int lat);
    return (m ? 1600 : 19200) + lat + 1;
  endfunction

  always @(posedge clk or negedge resetn) begin
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        mIdle[d] <= 1'b1;
        mRst[d]  <= 1'b1;
        mCyc[d]  <= 0;
      end else if (mIdle[d]) begin
        if (start) begin
          mIdle[d]  <= 1'b0;
          mRst[d]   <= 1'b0;
          mCyc[d]   <= 1;
          mMode[d]  <= mode;
          mBlack[d] <= black;
          mOx[d]    <= int'(xo);
          mOy[d]    <= int'(yo);
          mExp[d]   <= tExp;
          mDone[d]  <= (d == 0) ? tDone1 : tDone2;
        end
      end else if (mCyc[d] == lastCyc(mMode[d], d + 1)) begin
        mIdle[d] <= 1'b1;
      end else begin
        mCyc[d] <= mCyc[d] + 1;
      end
    end
  end

  task automatic chk(string nm, int d, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut_lat%0d t=%0t: got %0d expected %0d", nm, d + 1, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int lat, n, w, c, p, ex, ey;
      bit vis;
      lat = d + 1;
      if (mIdle[d]) begin
        chk("busy_idle", d, int'(oBusy[d]), 0);
        chk("done_idle", d, int'(oDone[d]), 0);
        chk("plot_idle", d, int'(oPlot[d]), 0);
        if (mRst[d]) begin
          chk("rst_addr", d, int'(oAddr[d]), 0);
          chk("rst_x", d, int'(oX[d]), 0);
          chk("rst_y", d, int'(oY[d]), 0);
          chk("rst_color", d, int'(oColor[d]), 0);
        end
      end else begin
        c = mCyc[d];
        n = mMode[d] ? 1600 : 19200;
        w = mMode[d] ? 40 : 160;
        if (c == 1) plotCnt[d] = 0;
        chk("busy", d, int'(oBusy[d]), (c <= n + lat) ? 1 : 0);
        chk("done", d, int'(oDone[d]), (c == n + lat + 1) ? 1 : 0);
        if (c <= n) chk("rom_addr", d, int'(oAddr[d]), c - 1);
        p = c - 1 - lat;
        if (p >= 0 && p < n) begin
          ex  = (mMode[d] ? mOx[d] : 0) + p % w;
          ey  = (mMode[d] ? mOy[d] : 0) + p / w;
          vis = (ex < 160) && (ey < 120);
          chk("plot", d, int'(oPlot[d]), vis ? 1 : 0);
          if (vis && oPlot[d]) begin
            chk("x", d, int'(oX[d]), ex);
            chk("y", d, int'(oY[d]), ey);
            chk("color", d, int'(oColor[d]), mBlack[d] ? 0 : p % 8);
          end
        end else begin
          chk("plot_gap", d, int'(oPlot[d]), 0);
        end
        if (oPlot[d]) plotCnt[d]++;
        if (oDone[d]) begin
          chk("done_cycle", d, c, mDone[d]);
          chk("plot_count", d, plotCnt[d], mExp[d]);
        end
      end
    end
  end

  task automatic waitIdle();
    bit ok = 1'b0;
    for (int k = 0; k < 25000; k++) begin
      @(negedge clk);
      if (mIdle[0] && mIdle[1]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL wait_idle: draw did not finish within 25000 cycles");
      $fatal(1);
    end
  endtask

  task automatic doStart(bit m, bit b, int ox, int oy, int ex, int dn1, int dn2);
    @(negedge clk);
    mode = m; black = b; xo = 8'(ox); yo = 7'(oy);
    tExp = ex; tDone1 = dn1; tDone2 = dn2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the draw must only use what was latched.
    mode = 1'($urandom_range(0, 1));
    black = 1'($urandom_range(0, 1));
    xo = 8'($urandom_range(0, 255));
    yo = 7'($urandom_range(0, 127));
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic int visSpan(int o, int lim);
    if (o >= lim) return 0;
    return (lim - o < 40) ? lim - o : 40;
  endfunction

  typedef struct {
    bit m;
    bit b;
    int ox;
    int oy;
    int exp;
    int dn1;
    int dn2;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{m: 1'b1, b: 1'b0, ox: 10,  oy: 20,  exp: 1600,  dn1: 1602,  dn2: 1603};
    vecs[1] = '{m: 1'b1, b: 1'b0, ox: 140, oy: 100, exp: 400,   dn1: 1602,  dn2: 1603};
    vecs[2] = '{m: 1'b1, b: 1'b1, ox: 0,   oy: 0,   exp: 1600,  dn1: 1602,  dn2: 1603};
    vecs[3] = '{m: 1'b0, b: 1'b1, ox: 77,  oy: 33,  exp: 19200, dn1: 19202, dn2: 19203};
    vecs[4] = '{m: 1'b1, b: 1'b0, ox: 150, oy: 5,   exp: 400,   dn1: 1602,  dn2: 1603};
    vecs[5] = '{m: 1'b1, b: 1'b0, ox: 0,   oy: 110, exp: 400,   dn1: 1602,  dn2: 1603};
    vecs[6] = '{m: 1'b1, b: 1'b0, ox: 200, oy: 10,  exp: 0,     dn1: 1602,  dn2: 1603};

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Held start in screen mode: full draw, one idle cycle, re-trigger, then abort by reset.
    mode = 1'b0; black = 1'b0; xo = 8'd0; yo = 7'd0;
    tExp = 19200; tDone1 = 19202; tDone2 = 19203;
    start = 1'b1;
    repeat (19300) @(negedge clk);
    start = 1'b0;
    pulseReset();
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      doStart(vecs[i].m, vecs[i].b, vecs[i].ox, vecs[i].oy, vecs[i].exp, vecs[i].dn1,
              vecs[i].dn2);
      waitIdle();
    end

    // Sprite draw with an ignored second start, then reset mid-draw.
    doStart(1'b1, 1'b0, 30, 40, 1600, 1602, 1603);
    repeat (498) @(negedge clk);
    mode = 1'b0; black = 1'b1; xo = 8'd0; yo = 7'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    pulseReset();
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      int ox, oy;
      bit b;
      ox = int'($urandom_range(0, 255));
      oy = int'($urandom_range(0, 127));
      b  = 1'($urandom_range(0, 1));
      doStart(1'b1, b, ox, oy, visSpan(ox, 160) * visSpan(oy, 120), 1602, 1603);
      waitIdle();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
